// File: rtl/sar_conv_seq.sv
// Sequencer for an external SAR ADC: drives sample/start, collects
// 2^avg_log2 conversions, and presents the averaged result on a valid/ready port.
module sar_conv_seq #(
    parameter int DW          = 12,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          trig,
    input  logic [3:0]    sample_cycles,
    input  logic [1:0]    avg_log2,
    output logic          sar_sample,
    output logic          sar_start,
    input  logic [DW-1:0] sar_data,
    input  logic          sar_done,
    output logic [DW-1:0] res_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          busy,
    output logic          overrun,
    output logic          timeout_err,
    input  logic          clr_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        START,
        CONVERT,
        OUTPUT
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_sampleLen;
    logic [3:0]    r_sampleCnt;
    logic [3:0]    r_convCnt;
    logic [1:0]    r_avgLog2;
    logic [DW+2:0] r_acc;
    logic [TW-1:0] r_toCnt;

    logic          w_sampleEnd;
    logic          w_convDone;
    logic          w_timeout;
    logic          w_load;
    logic          w_xfer;
    logic [3:0]    w_convNext;
    logic [3:0]    w_batchLen;

    always_comb begin
        w_batchLen  = 4'd1 << r_avgLog2;
        w_convNext  = r_convCnt + 4'd1;
        w_sampleEnd = (r_sampleCnt == r_sampleLen - 4'd1);
        w_convDone  = (r_state == CONVERT) && sar_done;
        w_timeout   = (r_state == CONVERT) && !sar_done &&
                      (r_toCnt == TW'(TIMEOUT_CYC - 1));
        w_load      = (r_state == OUTPUT);
        w_xfer      = res_valid && res_ready;
        sar_sample  = (r_state == SAMPLE);
        sar_start   = (r_state == START);
        busy        = (r_state != IDLE);
        w_next      = r_state;
        case (r_state)
            IDLE:    if (en || trig) w_next = SAMPLE;
            SAMPLE:  if (w_sampleEnd) w_next = START;
            START:   w_next = CONVERT;
            CONVERT: begin
                if (w_convDone)
                    w_next = (w_convNext == w_batchLen) ? OUTPUT : SAMPLE;
                else if (w_timeout)
                    w_next = IDLE;
            end
            OUTPUT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Batch configuration is captured every IDLE cycle, so the value present
    // on the launching edge is what the whole batch uses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sampleLen <= 4'd1;
            r_sampleCnt <= '0;
            r_convCnt   <= '0;
            r_avgLog2   <= '0;
            r_acc       <= '0;
            r_toCnt     <= '0;
        end else begin
            r_toCnt <= '0;
            case (r_state)
                IDLE: begin
                    r_sampleLen <= (sample_cycles == 4'd0) ? 4'd1 : sample_cycles;
                    r_avgLog2   <= avg_log2;
                    r_acc       <= '0;
                    r_convCnt   <= '0;
                    r_sampleCnt <= '0;
                end
                SAMPLE: r_sampleCnt <= r_sampleCnt + 4'd1;
                CONVERT: begin
                    r_sampleCnt <= '0;
                    if (sar_done) begin
                        r_acc     <= r_acc + {3'b000, sar_data};
                        r_convCnt <= w_convNext;
                    end else begin
                        r_toCnt <= r_toCnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A set event on a sticky flag wins over clr_err in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_data    <= '0;
            res_valid   <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (w_load) begin
                res_data  <= DW'(r_acc >> r_avgLog2);
                res_valid <= 1'b1;
            end else if (w_xfer) begin
                res_valid <= 1'b0;
            end
            if (w_load && res_valid && !res_ready) overrun <= 1'b1;
            else if (clr_err)                       overrun <= 1'b0;
            if (w_timeout)    timeout_err <= 1'b1;
            else if (clr_err) timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sar_conv_seq.sv
// Directed bench for sar_conv_seq: the stimulus plays the SAR and pushes expected
// results into a scoreboard that a separate monitor drains on every transfer.
module tb_sar_conv_seq;

    localparam int DW = 12;

    logic          clk;
    logic          reset;
    logic          en;
    logic          trig;
    logic [3:0]    sample_cycles;
    logic [1:0]    avg_log2;
    logic          sar_sample;
    logic          sar_start;
    logic [DW-1:0] sar_data;
    logic          sar_done;
    logic [DW-1:0] res_data;
    logic          res_valid;
    logic          res_ready;
    logic          busy;
    logic          overrun;
    logic          timeout_err;
    logic          clr_err;

    int            numChecks = 0;
    int            numFails  = 0;
    int            numSample = 0;
    int            numStart  = 0;
    int            numXfer   = 0;
    logic [DW-1:0] sbQ[$];

    sar_conv_seq #(.DW(DW), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .reset(reset), .en(en), .trig(trig),
        .sample_cycles(sample_cycles), .avg_log2(avg_log2),
        .sar_sample(sar_sample), .sar_start(sar_start),
        .sar_data(sar_data), .sar_done(sar_done),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .overrun(overrun), .timeout_err(timeout_err),
        .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Sets the batch configuration and pulses trig for one cycle; returns in cycle 1.
    task automatic applyStimulus(input logic [3:0] sc, input logic [1:0] al);
        sample_cycles = sc;
        avg_log2      = al;
        trig          = 1'b1;
        tick();
        trig          = 1'b0;
    endtask

    task automatic waitStart();
        int n;
        n = 0;
        while (!sar_start && n < 50) begin
            tick();
            n++;
        end
        checkOutput("sarStartSeen", 32'(sar_start), 32'd1);
    endtask

    // Behaves as the SAR: answers the next sar_start after 'delay' cycles.
    task automatic doConv(input logic [DW-1:0] data, input int delay, input logic trigDuring);
        waitStart();
        for (int i = 0; i < delay; i++) begin
            tick();
            if (trigDuring) trig = (i == 0);
        end
        trig     = 1'b0;
        sar_data = data;
        sar_done = 1'b1;
        tick();
        sar_done = 1'b0;
        sar_data = '0;
    endtask

    initial begin
        logic [DW-1:0] expected;
        forever begin
            @(negedge clk);
            #3;
            if (sar_sample) numSample++;
            if (sar_start)  numStart++;
            if (res_valid && res_ready) begin
                numXfer++;
                if (sbQ.size() == 0) begin
                    numChecks++;
                    numFails++;
                    $display("[TB] FAIL unexpectedResult: got 0x%0h, expected no result", res_data);
                end else begin
                    expected = sbQ.pop_front();
                    checkOutput("scoreboardResData", 32'(res_data), 32'(expected));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        reset = 1'b1; en = 1'b0; trig = 1'b0; sample_cycles = 4'd0; avg_log2 = 2'd0;
        sar_data = '0; sar_done = 1'b0; res_ready = 1'b0; clr_err = 1'b0;
        repeat (3) tick();
        checkOutput("rstSarSample", 32'(sar_sample), 32'd0);
        checkOutput("rstSarStart", 32'(sar_start), 32'd0);
        checkOutput("rstResData", 32'(res_data), 32'd0);
        checkOutput("rstResValid", 32'(res_valid), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstOverrun", 32'(overrun), 32'd0);
        checkOutput("rstTimeout", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        tick();

        $display("[TB] single shot");
        numSample = 0; numStart = 0;
        sbQ.push_back(12'hABC);
        applyStimulus(4'd4, 2'd0);
        n = 1;
        while (!sar_start && n < 30) begin
            tick();
            n++;
        end
        checkOutput("startLatency", 32'(n), 32'd5);
        repeat (12) tick();
        sar_data = 12'hABC; sar_done = 1'b1;
        tick();
        sar_done = 1'b0; sar_data = '0;
        checkOutput("validNotEarly", 32'(res_valid), 32'd0);
        tick();
        checkOutput("validLatency", 32'(res_valid), 32'd1);
        repeat (3) tick();
        checkOutput("validHeld", 32'(res_valid), 32'd1);
        checkOutput("dataHeld", 32'(res_data), 32'hABC);
        checkOutput("singleSamples", 32'(numSample), 32'd4);
        checkOutput("singleStarts", 32'(numStart), 32'd1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checkOutput("validCleared", 32'(res_valid), 32'd0);

        $display("[TB] averaging of four");
        numSample = 0; numStart = 0;
        res_ready = 1'b1;
        sbQ.push_back(12'd101);
        applyStimulus(4'd2, 2'd2);
        sample_cycles = 4'd0;
        avg_log2 = 2'd0;
        doConv(12'd100, 3, 1'b0);
        sar_data = 12'hFFF; sar_done = 1'b1;
        tick();
        sar_done = 1'b0; sar_data = '0;
        doConv(12'd101, 3, 1'b1);
        doConv(12'd102, 3, 1'b0);
        doConv(12'd104, 3, 1'b0);
        repeat (3) tick();
        checkOutput("avgStarts", 32'(numStart), 32'd4);
        checkOutput("avgSamples", 32'(numSample), 32'd8);
        checkOutput("avgIdle", 32'(busy), 32'd0);
        checkOutput("avgXfers", 32'(numXfer), 32'd2);

        $display("[TB] zero sample cycles");
        numSample = 0;
        sbQ.push_back(12'h123);
        applyStimulus(4'd0, 2'd0);
        n = 1;
        while (!sar_start && n < 30) begin
            tick();
            n++;
        end
        checkOutput("zeroSampleLatency", 32'(n), 32'd2);
        doConv(12'h123, 2, 1'b0);
        repeat (3) tick();
        checkOutput("zeroSampleCount", 32'(numSample), 32'd1);

        $display("[TB] overrun with continuous enable");
        res_ready = 1'b0;
        sample_cycles = 4'd1; avg_log2 = 2'd0;
        sbQ.push_back(12'h222);
        en = 1'b1;
        doConv(12'h111, 2, 1'b0);
        n = 0;
        while (!res_valid && n < 10) begin
            tick();
            n++;
        end
        checkOutput("firstResult", 32'(res_data), 32'h111);
        checkOutput("noOverrunYet", 32'(overrun), 32'd0);
        tick();
        en = 1'b0;
        doConv(12'h222, 2, 1'b0);
        tick();
        checkOutput("overrunSet", 32'(overrun), 32'd1);
        checkOutput("overwrittenData", 32'(res_data), 32'h222);
        checkOutput("overrunIdle", 32'(busy), 32'd0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checkOutput("overrunCleared", 32'(overrun), 32'd0);
        checkOutput("validAfterClr", 32'(res_valid), 32'd1);

        $display("[TB] timeout");
        applyStimulus(4'd1, 2'd0);
        waitStart();
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        checkOutput("timeoutCycles", 32'(n), 32'd65);
        checkOutput("timeoutFlag", 32'(timeout_err), 32'd1);
        checkOutput("timeoutValidKept", 32'(res_valid), 32'd1);
        checkOutput("timeoutDataKept", 32'(res_data), 32'h222);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checkOutput("timeoutCleared", 32'(timeout_err), 32'd0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checkOutput("overrunDrained", 32'(res_valid), 32'd0);

        $display("[TB] reset mid-batch");
        applyStimulus(4'd1, 2'd2);
        doConv(12'd50, 2, 1'b0);
        waitStart();
        repeat (2) tick();
        checkOutput("preResetBusy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstSample", 32'(sar_sample), 32'd0);
        checkOutput("midRstStart", 32'(sar_start), 32'd0);
        checkOutput("midRstValid", 32'(res_valid), 32'd0);
        checkOutput("midRstData", 32'(res_data), 32'd0);
        reset = 1'b0;
        sar_data = 12'h0FF; sar_done = 1'b1;
        tick();
        sar_done = 1'b0; sar_data = '0;
        repeat (20) tick();
        checkOutput("noResultAfterRst", 32'(res_valid), 32'd0);
        checkOutput("idleAfterRst", 32'(busy), 32'd0);

        checkOutput("totalXfers", 32'(numXfer), 32'd4);
        checkOutput("scoreboardEmpty", 32'(sbQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule

// File: doc/sar_conv_seq.md
SAR_CONV_SEQ -- requirements
Module: sar_conv_seq

Interface
REQ-001 SHALL have parameter DW, default 12, SAR result width.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 64, maximum CONVERT cycles allowed before abort.
REQ-003 SHALL have port clk  input  1  single clock; all logic updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  continuous-conversion enable.
REQ-006 SHALL have port trig  input  1  single-shot batch request.
REQ-007 SHALL have port sample_cycles  input  4  sample-phase length in cycles; 0 treated as 1.
REQ-008 SHALL have port avg_log2  input  2  batch size of 2^avg_log2 conversions (1, 2, 4 or 8).
REQ-009 SHALL have port sar_sample  output  1  sample/hold switch drive; high only in SAMPLE.
REQ-010 SHALL have port sar_start  output  1  one-cycle conversion start pulse to the SAR logic.
REQ-011 SHALL have port sar_data  input  DW  SAR result; valid only in the sar_done cycle.
REQ-012 SHALL have port sar_done  input  1  SAR conversion-complete pulse.
REQ-013 SHALL have port res_data  output  DW  averaged result.
REQ-014 SHALL have port res_valid  output  1  result-available flag.
REQ-015 SHALL have port res_ready  input  1  consumer accept; a transfer occurs when res_valid && res_ready.
REQ-016 SHALL have port busy  output  1  high when state != IDLE.
REQ-017 SHALL have port overrun  output  1  sticky: an unaccepted result was overwritten.
REQ-018 SHALL have port timeout_err  output  1  sticky: sar_done missing within TIMEOUT_CYC cycles.
REQ-019 SHALL have port clr_err  input  1  clears both sticky flags.

Function
REQ-020 SHALL implement states IDLE, SAMPLE, START, CONVERT, OUTPUT.
REQ-021 IDLE: with (en || trig) SHALL go to SAMPLE next edge; SHALL latch avg_log2 and sample_cycles and zero the accumulator and conversion count.
REQ-022 SAMPLE SHALL last exactly max(sample_cycles,1) cycles with sar_sample=1, then go to START.
REQ-023 START SHALL last exactly 1 cycle with sar_start=1 and sar_sample=0, then go to CONVERT.
REQ-024 CONVERT: on sar_done SHALL add zero-extended sar_data into a DW+3-bit accumulator and increment the count; if count reaches 2^avg_log2, go to OUTPUT, else go to SAMPLE.
REQ-025 OUTPUT SHALL last 1 cycle; at its end, res_data SHALL be set to accumulator >> latched avg_log2 (truncating) and res_valid to 1; the next state SHALL be IDLE.
REQ-026 res_valid and res_data SHALL hold until a transfer; res_valid SHALL clear on the transfer edge unless a new result loads on that same edge.
REQ-027 A new result loaded while res_valid=1 and res_ready=0 SHALL overwrite res_data and set overrun; a result loaded in the same cycle as a transfer SHALL NOT set overrun.
REQ-028 If CONVERT persists TIMEOUT_CYC cycles without sar_done, SHALL set timeout_err, discard the batch, produce no result and go to IDLE.
REQ-029 trig while busy SHALL be ignored; sar_done outside CONVERT SHALL be ignored.
REQ-030 Deasserting en mid-batch SHALL let the batch complete; held en SHALL restart from IDLE with one IDLE cycle between batches.
REQ-031 clr_err SHALL clear both sticky flags on the next edge; a same-cycle set event SHALL take priority over the clear.
REQ-032 Latency: trig at edge 0, sample_cycles=4, avg_log2=0 -> SAMPLE cycles 1-4, sar_start cycle 5, CONVERT from cycle 6; sar_done in cycle T -> res_valid high from cycle T+2.

Reset
REQ-033 reset SHALL force IDLE on the next edge from any state, including mid-batch, and discard any batch in progress.
REQ-034 reset SHALL clear the accumulator, count and timeout counter, and drive all outputs to 0 (sar_sample, sar_start, res_data, res_valid, busy, overrun, timeout_err).

Verification
REQ-035 Single shot: trig pulse, sample_cycles=4, avg_log2=0, sar_done 12 cycles after sar_start with sar_data=0xABC -> exactly 4 sar_sample cycles, one sar_start, res_data=0xABC, res_valid held until res_ready.
REQ-036 Averaging: avg_log2=2, sar_data 100, 101, 102, 104 -> four sar_start pulses, res_data=101 (407>>2), a single res_valid.
REQ-037 Overrun: en=1, res_ready=0, two results complete -> overrun=1, res_data equals second result; clr_err -> overrun=0.
REQ-038 Timeout: no sar_done for 64 CONVERT cycles -> timeout_err=1, busy=0, res_valid unchanged.
REQ-039 Reset mid-batch: reset in CONVERT of a 4-conversion batch -> IDLE next edge, all outputs 0, no result emitted.
REQ-040 Edge cases: sample_cycles=0 -> exactly 1 SAMPLE cycle; trig during CONVERT ignored; sar_done during SAMPLE ignored.
